// File: rtl/mdu_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_if -- EX-stage <-> multiply/divide controller handshake.
//
// Signals:
//   req       EX-stage instruction needs the MDU (held while stalled)
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a/b   rs / rt operand values
//   flush     cancel the in-flight operation
//   stallreq  stall request towards the pipeline stall controller
//   busy      controller is not idle
//   hi/lo     architectural HI/LO registers
//
// Modports: master = pipeline side, slave = mdu_ctrl side.
// ---------------------------------------------------------------------------
interface mdu_ctrl_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, op, src_a, src_b, flush,
    input  stallreq, busy, hi, lo
  );

  modport slave (
    input  req, op, src_a, src_b, flush,
    output stallreq, busy, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- sequences multiply/divide instructions from the EX stage onto
// an external multiplier and divider, stalls the pipeline while they run and
// owns the HI/LO registers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex (mdu_ctrl_if.slave)   EX-stage request, flush, stall, busy, HI/LO
//   mul_ina/inb, mul_signed  multiplier operands (driven only in MUL_WAIT)
//   mul_result               multiplier product
//   div_start/signed/annul   divider control (driven only in DIV_WAIT)
//   div_opa/opb              divider operands
//   div_ready, div_result    divider completion, {remainder, quotient}
//
// Parameter MUL_LAT (1..7): multiplier latency; a multiply stalls the
// pipeline for MUL_LAT+1 cycles (request cycle + MUL_LAT wait cycles).
// ---------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  mdu_ctrl_if.slave   ex,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [2:0] LAT_LOAD = 3'(MUL_LAT);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opb_q;
  logic        sgn_q;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        load_ops;
  logic        stall;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: operand latches are ordinary registers and are cleared on
      // reset so the idle operand buses never carry stale values.
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load_ops) begin
        opa_q <= ex.src_a;
        opb_q <= ex.src_b;
        sgn_q <= ~ex.op[0];     // MULT/DIV signed, MULTU/DIVU unsigned
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    load_ops   = 1'b0;
    stall      = 1'b0;
    mul_ina    = '0;
    mul_inb    = '0;
    mul_signed = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_opa    = '0;
    div_opb    = '0;

    // During reset every output stays low and nothing is committed; the
    // register block forces the state back to IDLE on the edge.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          // A request flushed in the same cycle is dropped outright: no
          // stall, no HI/LO write.
          if (ex.req && !ex.flush) begin
            case (ex.op)
              OP_MULT, OP_MULTU: begin
                load_ops = 1'b1;
                cnt_d    = LAT_LOAD;
                stall    = 1'b1;
                state_d  = MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                load_ops = 1'b1;
                stall    = 1'b1;
                state_d  = DIV_WAIT;
              end
              OP_MTHI: hi_d = ex.src_a;
              OP_MTLO: lo_d = ex.src_a;
              default: ;
            endcase
          end
        end

        MUL_WAIT: begin
          mul_ina    = opa_q;
          mul_inb    = opb_q;
          mul_signed = sgn_q;
          if (ex.flush) begin
            state_d = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              hi_d    = mul_result[63:32];
              lo_d    = mul_result[31:0];
              state_d = DONE;
            end
          end
        end

        DIV_WAIT: begin
          div_opa    = opa_q;
          div_opb    = opb_q;
          div_signed = sgn_q;
          div_start  = ~div_ready;
          if (ex.flush) begin
            div_annul = 1'b1;
            state_d   = IDLE;
          end else begin
            stall = 1'b1;
            if (div_ready) begin
              hi_d    = div_result[63:32];
              lo_d    = div_result[31:0];
              state_d = DONE;
            end
          end
        end

        // Stall released for one cycle so the instruction leaves EX; a req
        // still visible here belongs to that same instruction.
        DONE: state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end
  end

  assign ex.stallreq = stall;
  assign ex.busy     = !rst && (state_q != IDLE);
  assign ex.hi       = rst ? '0 : hi_q;
  assign ex.lo       = rst ? '0 : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl with behavioural
// multiplier (combinational product) and divider (ready after DIV_LAT wait
// cycles, {remainder, quotient}) models.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdu_ctrl;

  localparam int unsigned MUL_LAT  = 1;
  localparam int          DIV_LAT  = 33;
  localparam int          MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mul_ina, mul_inb;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul;
  logic [31:0] div_opa, div_opb;
  logic        div_ready;
  logic [63:0] div_result;
  int          div_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex         (bus),
    .mul_ina    (mul_ina),
    .mul_inb    (mul_inb),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .div_opa    (div_opa),
    .div_opb    (div_opb),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  // Multiplier model: product valid as long as operands are held.
  always_comb begin
    if (mul_signed)
      mul_result = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
    else
      mul_result = {32'd0, mul_ina} * {32'd0, mul_inb};
  end

  // Divider model: ready on the DIV_LAT-th cycle of continuous start.
  always @(posedge clk) begin
    if (rst || div_annul || !div_start) div_cnt <= 0;
    else                                div_cnt <= div_cnt + 1;
  end
  assign div_ready = (div_cnt == DIV_LAT - 1);

  logic signed [31:0] sq, sr;
  always_comb begin
    sq = '0;
    sr = '0;
    if (div_opb == 32'd0) begin
      div_result = {div_opa, 32'hFFFF_FFFF};
    end else if (div_signed) begin
      sq = $signed(div_opa) / $signed(div_opb);
      sr = $signed(div_opa) % $signed(div_opb);
      div_result = {sr, sq};
    end else begin
      div_result = {div_opa % div_opb, div_opa / div_opb};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and counts stalled cycles; returns in the first
  // cycle with stallreq low (DONE for mul/div). n = -1 on timeout.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    bus.req   = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    n = 0;
    #1;
    while (bus.stallreq === 1'b1 && n < MAX_WAIT) begin
      n++;
      step();
    end
    if (n >= MAX_WAIT) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.stallreq, bus.busy, div_annul, div_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_during_ctrl: got %b expected 0000", {bus.stallreq, bus.busy, div_annul, div_start});
    end
    step();
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
    end
    n_checks++;
    if ({bus.stallreq, bus.busy, mul_signed, div_signed} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_after_ctrl: got %b expected 0000", {bus.stallreq, bus.busy, mul_signed, div_signed});
    end
  endtask

  task automatic test_mult(input logic [2:0] o, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string name);
    int n;
    issue(o, 32'hFFFF_FFFE, 32'd3, n);
    n_checks++;
    if (n != int'(MUL_LAT) + 1) begin
      n_fail++;
      $display("FAIL %s_stall_cycles: got %0d expected %0d", name, n, MUL_LAT + 1);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin
      n_fail++;
      $display("FAIL %s_hilo: got %h expected %h", name, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end
    n_checks++;
    if ({bus.busy, mul_ina} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL %s_done_state: got busy=%b mul_ina=%h expected busy=1 mul_ina=0", name, bus.busy, mul_ina);
    end
    step();              // DONE edge with req still high
    bus.req = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.stallreq} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_back_to_idle: got %b expected 00", name, {bus.busy, bus.stallreq});
    end
  endtask

  task automatic test_mthi_mtlo();
    bus.req = 1'b1; bus.op = 3'd4; bus.src_a = 32'h1234_5678; bus.src_b = 32'd0;
    #1;
    n_checks++;
    if (bus.stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_stall: got %b expected 0", bus.stallreq);
    end
    step();
    bus.op = 3'd5; bus.src_a = 32'h9ABC_DEF0;
    #1;
    n_checks++;
    if ({bus.hi, bus.stallreq, bus.busy} !== {32'h1234_5678, 2'b00}) begin
      n_fail++;
      $display("FAIL mthi_write: got hi=%h stall/busy=%b expected hi=12345678 00", bus.hi, {bus.stallreq, bus.busy});
    end
    step();
    bus.req = 1'b0;
    #1;
    n_checks++;
    if ({bus.hi, bus.lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin
      n_fail++;
      $display("FAIL mtlo_write: got %h expected 123456789abcdef0", {bus.hi, bus.lo});
    end
  endtask

  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, n);   // -7 / 2
    n_checks++;
    if (n != DIV_LAT + 1) begin
      n_fail++;
      $display("FAIL div_stall_cycles: got %0d expected %0d", n, DIV_LAT + 1);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL div_hilo: got %h expected fffffffffffffffd", {bus.hi, bus.lo});
    end
    step();
    bus.req = 1'b0;
    #1;
  endtask

  task automatic test_flush_div();
    int n;
    bus.req = 1'b1; bus.op = 3'd2; bus.src_a = 32'd50; bus.src_b = 32'd3;
    step();                                  // DIV_WAIT cycle 1
    n_checks++;
    if ({div_start, div_signed, div_annul, div_opa, div_opb} !== {3'b110, 32'd50, 32'd3}) begin
      n_fail++;
      $display("FAIL div_wait_drive: got %b %h %h expected 110 00000032 00000003",
               {div_start, div_signed, div_annul}, div_opa, div_opb);
    end
    for (int i = 0; i < 4; i++) step();      // DIV_WAIT cycle 5
    bus.flush = 1'b1;
    #1;
    n_checks++;
    if ({div_annul, bus.stallreq} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_annul: got annul/stall=%b expected 10", {div_annul, bus.stallreq});
    end
    step();
    bus.flush = 1'b0;
    bus.req   = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, div_annul, div_start, div_opa} !== {3'b000, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_idle: got %b opa=%h expected 000 opa=0", {bus.busy, div_annul, div_start}, div_opa);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++;
      $display("FAIL flush_hilo_kept: got %h expected fffffffffffffffd", {bus.hi, bus.lo});
    end
    issue(3'd3, 32'd100, 32'd7, n);
    n_checks++;
    if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin
      n_fail++;
      $display("FAIL divu_hilo: got %h expected 000000020000000e (stall %0d)", {bus.hi, bus.lo}, n);
    end
    step();
    bus.req = 1'b0;
    #1;
  endtask

  task automatic test_ignored_reqs();
    bus.req = 1'b1; bus.op = 3'd4; bus.src_a = 32'hDEAD_BEEF; bus.flush = 1'b1;
    #1;
    n_checks++;
    if (bus.stallreq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_flush_stall: got %b expected 0", bus.stallreq);
    end
    step();
    bus.flush = 1'b0;
    bus.op = 3'd6;
    #1;
    n_checks++;
    if ({bus.hi, bus.stallreq} !== {32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_flush_mthi: got hi=%h stall=%b expected hi=00000002 stall=0", bus.hi, bus.stallreq);
    end
    step();
    bus.req = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd2, 32'd14}) begin
      n_fail++;
      $display("FAIL reserved_op: got busy=%b hilo=%h expected busy=0 hilo=000000020000000e",
               bus.busy, {bus.hi, bus.lo});
    end
  endtask

  task automatic test_reset_mid_div();
    bus.req = 1'b1; bus.op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
    step();
    step();                                  // DIV_WAIT
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.stallreq, bus.busy, div_start, div_annul} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_div_ctrl: got %b expected 0000", {bus.stallreq, bus.busy, div_start, div_annul});
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.hi, bus.lo, bus.busy} !== {64'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_div_state: got hilo=%h busy=%b expected 0 0", {bus.hi, bus.lo}, bus.busy);
    end
    n_checks++;
    if (bus.stallreq !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release_restart: got stall=%b expected 1", bus.stallreq);
    end
    step();
    n_checks++;
    if ({bus.busy, div_opa} !== {1'b1, 32'd100}) begin
      n_fail++;
      $display("FAIL rst_restart_div: got busy=%b opa=%h expected busy=1 opa=00000064", bus.busy, div_opa);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.req   = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
    test_reset();
    test_mult(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    test_mult(3'd1, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    test_mthi_mtlo();
    test_div();
    test_flush_div();
    test_ignored_reqs();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
